// File: rtl/zdos_trap.sv
// Opcode-fetch trap detector: watches Z80 M1 fetches and requests DOS on/off
// with one-fclk pulses when a qualified fetch hits a trap address.
module zdos_trap (
    input  logic        fclk,
    input  logic        rst,
    input  logic [15:0] za,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        rd_n,
    input  logic        rfsh_n,
    input  logic        basic48,
    input  logic        dos,
    input  logic        trap_en,
    output logic        dos_turn_on,
    output logic        dos_turn_off,
    output logic [15:0] m1_addr,
    output logic [7:0]  trap_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] addr_lat;
    logic        fetch;
    logic        m1_end;
    logic        addr_match;
    logic        latch_addr;
    logic        qualify;
    logic        trig_on;
    logic        trig_off;

    assign fetch      = ~m1_n & ~mreq_n & ~rd_n & rfsh_n;
    assign m1_end     = m1_n | mreq_n;
    assign addr_match = (za == addr_lat);

    always_comb begin
        state_nxt  = state;
        latch_addr = 1'b0;
        qualify    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fetch) begin
                    state_nxt  = ST_QUAL;
                    latch_addr = 1'b1;
                end
            end
            ST_QUAL: begin
                // Two consecutive matching samples filter out bus glitches.
                if (fetch && addr_match) begin
                    state_nxt = ST_HOLD;
                    qualify   = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (m1_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The dos term makes the two requests mutually exclusive.
    assign trig_on  = qualify & trap_en & ~dos & basic48 & (za[15:8] == 8'h3D);
    assign trig_off = qualify & trap_en & dos & (za[15:14] != 2'b00);

    always_ff @(posedge fclk) begin
        if (rst) begin
            // HOLD ignores any M1 cycle still in flight when reset releases.
            state        <= ST_HOLD;
            addr_lat     <= 16'h0000;
            m1_addr      <= 16'h0000;
            dos_turn_on  <= 1'b0;
            dos_turn_off <= 1'b0;
            trap_cnt     <= 8'h00;
        end else begin
            state        <= state_nxt;
            dos_turn_on  <= trig_on;
            dos_turn_off <= trig_off;
            if (latch_addr) begin
                addr_lat <= za;
            end
            if (qualify) begin
                m1_addr <= za;
            end
            if (trig_on && (trap_cnt != 8'hFF)) begin
                trap_cnt <= trap_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_zdos_trap.sv
// Directed bench for zdos_trap: a table of M1-cycle records plus hand-written
// sequences for counter saturation and reset during a fetch.
module tb_zdos_trap;

    logic        fclk;
    logic        rst;
    logic [15:0] za;
    logic        m1_n;
    logic        mreq_n;
    logic        rd_n;
    logic        rfsh_n;
    logic        basic48;
    logic        dos;
    logic        trap_en;
    logic        dos_turn_on;
    logic        dos_turn_off;
    logic [15:0] m1_addr;
    logic [7:0]  trap_cnt;

    zdos_trap dut (
        .fclk         (fclk),
        .rst          (rst),
        .za           (za),
        .m1_n         (m1_n),
        .mreq_n       (mreq_n),
        .rd_n         (rd_n),
        .rfsh_n       (rfsh_n),
        .basic48      (basic48),
        .dos          (dos),
        .trap_en      (trap_en),
        .dos_turn_on  (dos_turn_on),
        .dos_turn_off (dos_turn_off),
        .m1_addr      (m1_addr),
        .trap_cnt     (trap_cnt)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    // Bus cycle kinds
    localparam int K_FETCH = 0;
    localparam int K_RFSH  = 1;
    localparam int K_READ  = 2;
    localparam int K_WRITE = 3;
    localparam int K_IDLE  = 4;

    typedef struct {
        logic [15:0] za;
        logic [15:0] za2;
        int          n;
        int          kind;
        logic        b48;
        logic        dos;
        logic        en;
        logic        flip;
        int          exp_on;
        int          exp_off;
        logic [15:0] exp_addr;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    int on_n;
    int off_n;
    int both_n;
    int first_idx;

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] a2, input int n,
                                input int kind, input logic b48, input logic d,
                                input logic en, input logic flip, input int eon,
                                input int eoff, input logic [15:0] eaddr);
        vec_t v;
        v.za = a; v.za2 = a2; v.n = n; v.kind = kind; v.b48 = b48; v.dos = d;
        v.en = en; v.flip = flip; v.exp_on = eon; v.exp_off = eoff; v.exp_addr = eaddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bus(input int kind, input logic [15:0] a);
        za = a;
        case (kind)
            K_FETCH: begin m1_n = 0; mreq_n = 0; rd_n = 0; rfsh_n = 1; end
            K_RFSH:  begin m1_n = 1; mreq_n = 0; rd_n = 1; rfsh_n = 0; end
            K_READ:  begin m1_n = 1; mreq_n = 0; rd_n = 0; rfsh_n = 1; end
            K_WRITE: begin m1_n = 1; mreq_n = 0; rd_n = 1; rfsh_n = 1; end
            default: begin m1_n = 1; mreq_n = 1; rd_n = 1; rfsh_n = 1; end
        endcase
    endtask

    // One clock; outputs sampled 1 ns after the rising edge.
    task automatic tick(input int idx);
        @(posedge fclk);
        #1;
        if (dos_turn_on) begin
            on_n++;
            if (first_idx < 0) first_idx = idx;
        end
        if (dos_turn_off) begin
            off_n++;
            if (first_idx < 0) first_idx = idx;
        end
        if (dos_turn_on && dos_turn_off) both_n++;
    endtask

    task automatic run_m1(input vec_t v, input string tag);
        on_n = 0; off_n = 0; both_n = 0; first_idx = -1;
        basic48 = v.b48;
        trap_en = v.en;
        for (int i = 0; i < v.n + 2; i++) begin
            if (i < v.n) drive_bus(v.kind, (i == 0) ? v.za : v.za2);
            else         drive_bus(K_IDLE, v.za);
            dos = (v.flip && i >= 2) ? ~v.dos : v.dos;
            tick(i);
        end
        dos = v.dos;
        exp_cnt = exp_cnt + v.exp_on;
        if (exp_cnt > 255) exp_cnt = 255;
        check({tag, " on_pulses"},  on_n,  v.exp_on);
        check({tag, " off_pulses"}, off_n, v.exp_off);
        check({tag, " both_high"},  both_n, 0);
        if (v.exp_on + v.exp_off > 0) check({tag, " pulse_cycle"}, first_idx, 1);
        check({tag, " m1_addr"},  m1_addr,  v.exp_addr);
        check({tag, " trap_cnt"}, trap_cnt, exp_cnt);
    endtask

    vec_t vecs[$];

    initial begin
        //             za       za2      n  kind     b48 dos en flip on off addr
        vecs.push_back(mk(16'h3D2F, 16'h3D2F, 4, K_FETCH, 1, 0, 1, 0, 1, 0, 16'h3D2F));
        vecs.push_back(mk(16'h8000, 16'h8000, 4, K_FETCH, 1, 1, 1, 0, 0, 1, 16'h8000));
        vecs.push_back(mk(16'h3D00, 16'h3D00, 4, K_FETCH, 1, 1, 1, 0, 0, 0, 16'h3D00));
        vecs.push_back(mk(16'h3D55, 16'h3D55, 4, K_FETCH, 0, 0, 1, 0, 0, 0, 16'h3D55));
        vecs.push_back(mk(16'h3D00, 16'h3D00, 1, K_FETCH, 1, 0, 1, 0, 0, 0, 16'h3D55));
        vecs.push_back(mk(16'h3D00, 16'h3E00, 2, K_FETCH, 1, 0, 1, 0, 0, 0, 16'h3D55));
        vecs.push_back(mk(16'h3D00, 16'h3D00, 3, K_RFSH,  1, 0, 1, 0, 0, 0, 16'h3D55));
        vecs.push_back(mk(16'h3D00, 16'h3D00, 3, K_READ,  1, 0, 1, 0, 0, 0, 16'h3D55));
        vecs.push_back(mk(16'h3D00, 16'h3D00, 3, K_WRITE, 1, 0, 1, 0, 0, 0, 16'h3D55));
        vecs.push_back(mk(16'h3D00, 16'h3D00, 4, K_FETCH, 1, 0, 0, 0, 0, 0, 16'h3D00));
        vecs.push_back(mk(16'h0000, 16'h0000, 3, K_FETCH, 1, 1, 1, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(16'h4000, 16'h4000, 3, K_FETCH, 1, 1, 1, 0, 0, 1, 16'h4000));
        vecs.push_back(mk(16'hC123, 16'hC123, 3, K_FETCH, 1, 1, 0, 0, 0, 0, 16'hC123));
        vecs.push_back(mk(16'h3CFF, 16'h3CFF, 3, K_FETCH, 1, 0, 1, 0, 0, 0, 16'h3CFF));
        vecs.push_back(mk(16'h3DFF, 16'h3DFF, 3, K_FETCH, 1, 0, 1, 0, 1, 0, 16'h3DFF));
        vecs.push_back(mk(16'h3D00, 16'h3D00, 2, K_FETCH, 1, 0, 1, 0, 1, 0, 16'h3D00));
        vecs.push_back(mk(16'h3D20, 16'h3D20, 5, K_FETCH, 1, 0, 1, 1, 1, 0, 16'h3D20));

        rst = 1; basic48 = 1; dos = 0; trap_en = 1;
        drive_bus(K_IDLE, 16'h0000);
        on_n = 0; off_n = 0; both_n = 0; first_idx = -1;
        tick(0);
        tick(0);
        check("reset on",       dos_turn_on,  0);
        check("reset off",      dos_turn_off, 0);
        check("reset m1_addr",  m1_addr,      16'h0000);
        check("reset trap_cnt", trap_cnt,     8'h00);
        rst = 0;
        tick(0);

        foreach (vecs[i]) run_m1(vecs[i], $sformatf("vec%0d", i));

        // Drive trap_cnt to saturation, then one more qualifying fetch.
        for (int i = 0; i < 300 && exp_cnt < 255; i++) begin
            logic [15:0] a;
            a = {8'h3D, 8'(i)};
            run_m1(mk(a, a, 3, K_FETCH, 1, 0, 1, 0, 1, 0, a), "sat");
        end
        check("sat reached", trap_cnt, 8'hFF);
        run_m1(mk(16'h3D77, 16'h3D77, 3, K_FETCH, 1, 0, 1, 0, 1, 0, 16'h3D77), "sat hold");

        // Reset on the pulse cycle with the fetch still driven.
        on_n = 0; off_n = 0; both_n = 0; first_idx = -1;
        basic48 = 1; dos = 0; trap_en = 1;
        drive_bus(K_FETCH, 16'h3D00);
        tick(0);
        tick(1);
        check("pre-reset pulse", dos_turn_on, 1);
        rst = 1;
        tick(2);
        check("rst on",       dos_turn_on,  0);
        check("rst off",      dos_turn_off, 0);
        check("rst m1_addr",  m1_addr,      16'h0000);
        check("rst trap_cnt", trap_cnt,     8'h00);
        rst = 0;
        on_n = 0;
        for (int i = 0; i < 4; i++) tick(i);
        check("post-rst held fetch pulses", on_n, 0);
        drive_bus(K_IDLE, 16'h3D00);
        tick(0);
        exp_cnt = 0;
        run_m1(mk(16'h3D00, 16'h3D00, 3, K_FETCH, 1, 0, 1, 0, 1, 0, 16'h3D00), "post-rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
